// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the configurable UART core:
//               parity selection, TX/RX state encodings, bit-period divisor
//               and the RX FIFO entry layout.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Entries are sized for the widest legal frame; narrower frames zero-pad.
  localparam int c_max_data_bits = 8;

  typedef struct packed {
    logic [c_max_data_bits-1:0] data;
    logic                       parity_err;
    logic                       frame_err;
  } rx_entry_t;

  // Bit period in system clocks, truncated.
  function automatic int unsigned calc_div(input logic [27:0] clock_freq,
                                           input logic [23:0] baud_rate);
    return 32'(clock_freq) / 32'(baud_rate);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive FIFO with a sticky overrun
//               flag. Head entry is presented combinationally from storage.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             overrun
);

  localparam int              c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_ptr_one = (c_aw+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             r_overrun;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  // A pop on an empty FIFO is ignored; a pop frees the slot for a same-cycle push.
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  assign head_data = r_mem[r_rd_ptr[c_aw-1:0]];
  assign not_empty = !w_empty;
  assign overrun   = r_overrun;

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
        r_wr_ptr                  <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Sticky overrun: set on a dropped push, cleared by the next accepted pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (push && w_full && !w_do_pop) begin
      r_overrun <= 1'b1;
    end else if (w_do_pop) begin
      r_overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_core_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_cfg
// Description : Full-duplex UART with compile-time data width, parity and
//               stop-bit count, feeding a FWFT RX FIFO with error flags.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_core_cfg
  import uart_pkg::*;
#(
  parameter logic [27:0] CLOCK_FREQ    = 28'd100000000,
  parameter logic [23:0] BAUD_RATE     = 24'd9600,
  parameter int          DATA_BITS     = 8,
  parameter int          PARITY_MODE   = 0,
  parameter int          STOP_BITS     = 1,
  parameter int          RX_FIFO_DEPTH = 4
) (
  input  logic                 clk_10ns,
  input  logic                 uart_reset,
  input  logic                 uart_tx_start,
  input  logic [DATA_BITS-1:0] uart_transmit_data,
  output logic                 uart_tx_ready,
  output logic                 uart_tx_d_out,
  input  logic                 uart_rx_d_in,
  output logic [DATA_BITS-1:0] uart_received_data,
  output logic                 uart_rx_valid,
  input  logic                 uart_rx_read,
  output logic                 uart_rx_parity_err,
  output logic                 uart_rx_frame_err,
  output logic                 uart_rx_overrun
);

  localparam int unsigned        c_div        = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int                 c_cnt_w      = $clog2(c_div);
  localparam logic [c_cnt_w-1:0] c_bit_last   = c_cnt_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0] c_half_last  = c_cnt_w'(c_div / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
  localparam logic [2:0]         c_last_data  = 3'(DATA_BITS - 1);
  localparam logic               c_last_stop  = (STOP_BITS == 2);
  localparam parity_mode_t       c_parity     = parity_mode_t'(PARITY_MODE[1:0]);
  localparam logic               c_has_parity = (c_parity != NONE);
  localparam logic               c_odd        = (c_parity == ODD);

  // ---------------------------------------------------------------- TX ----
  tx_state_t            r_tx_state;
  logic [c_cnt_w-1:0]   r_tx_cnt;
  logic [2:0]           r_tx_bit;
  logic                 r_tx_stop;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_line;
  logic                 r_tx_ready;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end  = (r_tx_cnt == c_bit_last);
  assign uart_tx_d_out = r_tx_line;
  assign uart_tx_ready = r_tx_ready;

  // Transmit FSM: every bit is held for one full bit period; line and ready are registered.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (uart_tx_start) begin
            r_tx_shift <= uart_transmit_data;
            r_tx_par   <= (^uart_transmit_data) ^ c_odd;
            r_tx_line  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + c_cnt_one;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == c_last_data) begin
              if (c_has_parity) begin
                r_tx_line  <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_tx_line  <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_line  <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + c_cnt_one;
          end
        end
        TX_PARITY: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_line  <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + c_cnt_one;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_stop == c_last_stop) begin
              r_tx_ready <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_stop <= 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + c_cnt_one;
          end
        end
        default: begin
          r_tx_line  <= 1'b1;
          r_tx_ready <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX ----
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;
  rx_state_t            r_rx_state;
  logic [c_cnt_w-1:0]   r_rx_cnt;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_bit;
  logic                 r_rx_push;
  rx_entry_t            r_rx_entry;
  rx_entry_t            w_head;
  logic                 w_rx_bit_end;
  logic                 w_rx_half_end;

  assign w_rx_bit_end  = (r_rx_cnt == c_bit_last);
  assign w_rx_half_end = (r_rx_cnt == c_half_last);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_d_in;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Receive FSM: mid-bit sampling; the entry is pushed at the first stop-bit sample.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bit <= 1'b0;
      r_rx_push    <= 1'b0;
      r_rx_entry   <= '0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_half_end) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            // Line already back high at mid-start: treat as a glitch.
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_cnt_one;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == c_last_data) begin
              r_rx_state <= c_has_parity ? RX_PARITY : RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + c_cnt_one;
          end
        end
        RX_PARITY: begin
          if (w_rx_bit_end) begin
            r_rx_cnt     <= '0;
            r_rx_par_bit <= r_rx_sync;
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_cnt_one;
          end
        end
        RX_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt              <= '0;
            r_rx_push             <= 1'b1;
            r_rx_entry.data       <= c_max_data_bits'(r_rx_shift);
            r_rx_entry.parity_err <= c_has_parity &
                                     (r_rx_par_bit ^ (^r_rx_shift) ^ c_odd);
            r_rx_entry.frame_err  <= !r_rx_sync;
            r_rx_state            <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_cnt_one;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH ($bits(rx_entry_t))
  ) u_rx_fifo (
    .clk       (clk_10ns),
    .rst_n     (uart_reset),
    .push      (r_rx_push),
    .push_data (r_rx_entry),
    .pop       (uart_rx_read),
    .head_data (w_head),
    .not_empty (uart_rx_valid),
    .overrun   (uart_rx_overrun)
  );

  assign uart_received_data = w_head.data[DATA_BITS-1:0];
  assign uart_rx_parity_err = w_head.parity_err;
  assign uart_rx_frame_err  = w_head.frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_core_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core_cfg
// Description : Self-checking bench for uart_core_cfg. Unit A is 8N1, unit B
//               is 7E2; both run at DIV=10. Expected line bits and RX entries
//               come from a frame-level model and a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core_cfg;

  localparam logic [27:0] c_clk_freq = 28'd1000000;
  localparam logic [23:0] c_baud     = 24'd100000;
  localparam int          c_div      = 10;
  localparam int          c_depth    = 4;

  logic clk;
  logic rst_n;

  logic       a_start, a_ready, a_txd, a_line, a_loop, a_rxd;
  logic       a_valid, a_read, a_pe, a_fe, a_ovr;
  logic [7:0] a_tdata, a_rdata;

  logic       b_start, b_ready, b_txd, b_line, b_loop, b_rxd;
  logic       b_valid, b_read, b_pe, b_fe, b_ovr;
  logic [6:0] b_tdata, b_rdata;

  int n_checks;
  int n_pass;

  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic       ovr_a;
  logic       ovr_b;

  assign a_rxd = a_loop ? a_txd : a_line;
  assign b_rxd = b_loop ? b_txd : b_line;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_core_cfg #(
    .CLOCK_FREQ(c_clk_freq), .BAUD_RATE(c_baud), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1), .RX_FIFO_DEPTH(c_depth)
  ) u_dut_a (
    .clk_10ns(clk), .uart_reset(rst_n), .uart_tx_start(a_start),
    .uart_transmit_data(a_tdata), .uart_tx_ready(a_ready), .uart_tx_d_out(a_txd),
    .uart_rx_d_in(a_rxd), .uart_received_data(a_rdata), .uart_rx_valid(a_valid),
    .uart_rx_read(a_read), .uart_rx_parity_err(a_pe), .uart_rx_frame_err(a_fe),
    .uart_rx_overrun(a_ovr)
  );

  uart_core_cfg #(
    .CLOCK_FREQ(c_clk_freq), .BAUD_RATE(c_baud), .DATA_BITS(7),
    .PARITY_MODE(1), .STOP_BITS(2), .RX_FIFO_DEPTH(c_depth)
  ) u_dut_b (
    .clk_10ns(clk), .uart_reset(rst_n), .uart_tx_start(b_start),
    .uart_transmit_data(b_tdata), .uart_tx_ready(b_ready), .uart_tx_d_out(b_txd),
    .uart_rx_d_in(b_rxd), .uart_received_data(b_rdata), .uart_rx_valid(b_valid),
    .uart_rx_read(b_read), .uart_rx_parity_err(b_pe), .uart_rx_frame_err(b_fe),
    .uart_rx_overrun(b_ovr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic get_txd(input int u);   return (u == 0) ? a_txd   : b_txd;   endfunction
  function automatic logic get_ready(input int u); return (u == 0) ? a_ready : b_ready; endfunction
  function automatic logic get_valid(input int u); return (u == 0) ? a_valid : b_valid; endfunction
  function automatic logic get_pe(input int u);    return (u == 0) ? a_pe    : b_pe;    endfunction
  function automatic logic get_fe(input int u);    return (u == 0) ? a_fe    : b_fe;    endfunction
  function automatic logic get_ovr(input int u);   return (u == 0) ? a_ovr   : b_ovr;   endfunction
  function automatic logic [7:0] get_rdata(input int u);
    return (u == 0) ? a_rdata : {1'b0, b_rdata};
  endfunction

  task automatic set_line(input int u, input logic v);
    if (u == 0) a_line = v; else b_line = v;
  endtask

  task automatic set_tx(input int u, input logic start, input logic [7:0] data);
    if (u == 0) begin a_start = start; a_tdata = data; end
    else begin b_start = start; b_tdata = data[6:0]; end
  endtask

  task automatic set_read(input int u, input logic v);
    if (u == 0) a_read = v; else b_read = v;
  endtask

  // Line-level frame for unit u: start, data LSB first, optional parity, stop bits.
  function automatic void build_frame(input int u, input logic [7:0] data, input bit flip_par,
                                      input bit bad_stop, output logic [15:0] bits, output int n);
    int         nb;
    int         ns;
    int         ones;
    logic [3:0] idx;
    nb   = (u == 0) ? 8 : 7;
    ns   = (u == 0) ? 1 : 2;
    ones = 0;
    bits = '1;
    idx  = 4'd0;
    bits[idx] = 1'b0;
    idx = idx + 4'd1;
    for (int i = 0; i < nb; i++) begin
      bits[idx] = data[i];
      if (data[i]) ones++;
      idx = idx + 4'd1;
    end
    if (u != 0) begin
      bits[idx] = ((ones % 2) == 1) ^ flip_par;
      idx = idx + 4'd1;
    end
    for (int i = 0; i < ns; i++) begin
      bits[idx] = !(bad_stop && (i == 0));
      idx = idx + 4'd1;
    end
    n = int'(idx);
  endfunction

  task automatic model_push(input int u, input logic [7:0] data, input bit pe, input bit fe);
    logic [7:0] d;
    d = (u == 0) ? data : (data & 8'h7F);
    if (u == 0) begin
      if (q_a.size() < c_depth) q_a.push_back({d, pe, fe}); else ovr_a = 1'b1;
    end else begin
      if (q_b.size() < c_depth) q_b.push_back({d, pe, fe}); else ovr_b = 1'b1;
    end
  endtask

  task automatic model_pop(input int u);
    if (u == 0) begin
      if (q_a.size() > 0) begin void'(q_a.pop_front()); ovr_a = 1'b0; end
    end else begin
      if (q_b.size() > 0) begin void'(q_b.pop_front()); ovr_b = 1'b0; end
    end
  endtask

  task automatic check_state(input int u);
    int         size;
    logic [9:0] head;
    logic       ovr;
    size = (u == 0) ? q_a.size() : q_b.size();
    ovr  = (u == 0) ? ovr_a : ovr_b;
    check_eq("rx_valid", get_valid(u), size > 0);
    if (size > 0) begin
      head = (u == 0) ? q_a[0] : q_b[0];
      check_eq("rx_data", get_rdata(u), head[9:2]);
      check_eq("rx_parity_err", get_pe(u), head[1]);
      check_eq("rx_frame_err", get_fe(u), head[0]);
    end
    check_eq("rx_overrun", get_ovr(u), ovr);
  endtask

  task automatic do_pop(input int u);
    @(negedge clk);
    set_read(u, 1'b1);
    @(negedge clk);
    set_read(u, 1'b0);
    model_pop(u);
  endtask

  task automatic drain(input int u);
    while (((u == 0) ? q_a.size() : q_b.size()) > 0) do_pop(u);
  endtask

  task automatic drive_frame(input int u, input logic [7:0] data, input bit flip_par, input bit bad_stop);
    logic [15:0] bits;
    int          n;
    build_frame(u, data, flip_par, bad_stop, bits, n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      set_line(u, bits[i]);
      repeat (c_div) @(negedge clk);
    end
    set_line(u, 1'b1);
    repeat (2 * c_div) @(negedge clk);
    model_push(u, data, flip_par && (u != 0), bad_stop);
  endtask

  // Called just after the accepting edge: checks each bit mid-period and the frame length.
  task automatic tx_frame_check(input int u, input logic [7:0] data);
    logic [15:0] bits;
    int          n;
    build_frame(u, data, 1'b0, 1'b0, bits, n);
    for (int k = 0; k < n; k++) begin
      repeat (c_div / 2) @(posedge clk);
      #1;
      check_eq("tx_bit", get_txd(u), bits[k]);
      if (k == n - 1) check_eq("tx_busy_last_bit", get_ready(u), 1'b0);
      repeat (c_div - c_div / 2) @(posedge clk);
    end
    #1;
    check_eq("tx_ready_after_frame", get_ready(u), 1'b1);
    check_eq("tx_idle_after_frame", get_txd(u), 1'b1);
  endtask

  task automatic wait_ready(input int u);
    int budget;
    budget = 0;
    while (!get_ready(u) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check_eq("tx_ready_wait", get_ready(u), 1'b1);
  endtask

  task automatic send_tx(input int u, input logic [7:0] data);
    wait_ready(u);
    @(negedge clk);
    set_tx(u, 1'b1, data);
    @(posedge clk);
    @(negedge clk);
    set_tx(u, 1'b0, data);
    tx_frame_check(u, data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] d2;
    bit         fp;
    bit         bs;
    n_checks = 0;
    n_pass   = 0;
    ovr_a    = 1'b0;
    ovr_b    = 1'b0;
    rst_n    = 1'b0;
    a_start = 1'b0; a_tdata = '0; a_line = 1'b1; a_loop = 1'b1; a_read = 1'b0;
    b_start = 1'b0; b_tdata = '0; b_line = 1'b1; b_loop = 1'b1; b_read = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_a_txd", a_txd, 1'b1);
    check_eq("rst_a_ready", a_ready, 1'b1);
    check_eq("rst_b_txd", b_txd, 1'b1);
    check_eq("rst_b_ready", b_ready, 1'b1);
    check_eq("rst_a_rdata", a_rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check_state(0);
    check_state(1);

    // 8N1 loopback of 0xA5
    send_tx(0, 8'hA5);
    model_push(0, 8'hA5, 1'b0, 1'b0);
    check_state(0);
    do_pop(0);
    check_state(0);

    // Random 8N1 loopback traffic
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send_tx(0, d);
      model_push(0, d, 1'b0, 1'b0);
      check_state(0);
      do_pop(0);
    end

    // Start held high: back-to-back frames with a single ready cycle between them
    d  = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    wait_ready(0);
    @(negedge clk);
    set_tx(0, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    set_tx(0, 1'b1, d2);
    tx_frame_check(0, d);
    @(posedge clk);
    @(negedge clk);
    set_tx(0, 1'b0, d2);
    check_eq("b2b_ready_low", a_ready, 1'b0);
    tx_frame_check(0, d2);
    model_push(0, d, 1'b0, 1'b0);
    model_push(0, d2, 1'b0, 1'b0);
    check_state(0);
    drain(0);
    check_state(0);

    // 7E2: 0x35 has even parity 0, frame of 110 cycles
    send_tx(1, 8'h35);
    model_push(1, 8'h35, 1'b0, 1'b0);
    check_state(1);
    do_pop(1);
    b_loop = 1'b0;
    drive_frame(1, 8'h35, 1'b1, 1'b0);
    check_state(1);
    do_pop(1);

    // Random 7E2 frames with injected parity and stop errors
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom_range(0, 127));
      fp = bit'($urandom_range(0, 1));
      bs = ($urandom_range(0, 3) == 0);
      drive_frame(1, d, fp, bs);
      check_state(1);
      if ($urandom_range(0, 1) == 1) do_pop(1);
    end
    drain(1);
    check_state(1);

    // Frame error then a clean frame
    a_loop = 1'b0;
    drive_frame(0, 8'h3C, 1'b0, 1'b1);
    check_state(0);
    do_pop(0);
    drive_frame(0, 8'h11, 1'b0, 1'b0);
    check_state(0);
    do_pop(0);

    // Glitch rejection, then a clean frame proves the receiver is idle again
    @(negedge clk);
    a_line = 1'b0;
    repeat (3) @(negedge clk);
    a_line = 1'b1;
    repeat (3 * c_div) @(negedge clk);
    check_state(0);
    d = 8'($urandom_range(0, 255));
    drive_frame(0, d, 1'b0, 1'b0);
    check_state(0);
    drain(0);

    // Overrun: five frames, no reads
    for (int i = 1; i <= 5; i++) drive_frame(0, 8'(i), 1'b0, 1'b0);
    check_state(0);
    do_pop(0);
    check_state(0);
    for (int i = 0; i < 3; i++) begin
      do_pop(0);
      check_state(0);
    end

    // Random traffic with sparse reads; model tracks drops and overrun
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom_range(0, 255));
      bs = ($urandom_range(0, 3) == 0);
      drive_frame(0, d, 1'b0, bs);
      check_state(0);
      if ($urandom_range(0, 2) == 0) begin
        do_pop(0);
        check_state(0);
      end
    end
    drain(0);

    // Reset during TX bit 3 with a non-empty FIFO
    drive_frame(0, 8'h77, 1'b0, 1'b0);
    check_state(0);
    wait_ready(0);
    @(negedge clk);
    set_tx(0, 1'b1, 8'hF0);
    @(posedge clk);
    @(negedge clk);
    set_tx(0, 1'b0, 8'hF0);
    repeat (3 * c_div + c_div / 2) @(posedge clk);
    @(negedge clk);
    check_eq("pre_reset_tx_busy", a_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_txd", a_txd, 1'b1);
    check_eq("midrst_ready", a_ready, 1'b1);
    check_eq("midrst_valid", a_valid, 1'b0);
    check_eq("midrst_rdata", a_rdata, 8'h00);
    q_a.delete();
    q_b.delete();
    ovr_a = 1'b0;
    ovr_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    a_loop = 1'b1;
    @(negedge clk);
    check_state(0);
    d = 8'($urandom_range(0, 255));
    send_tx(0, d);
    model_push(0, d, 1'b0, 1'b0);
    check_state(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
